// File: rtl/mantle_test_pkg.sv
// Shared types and helpers for the NOr4x2 gate-array self-test driver.
// Holds the FSM state encoding, counter width and the expected-response function.
package mantle_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } tester_state_t;

  localparam int ERRCNT_W  = 8;
  localparam int MAX_WIDTH = 4;

  // Per-lane 4-input NOR of a J1-packed stimulus; lanes at or above width read as 0.
  function automatic logic [MAX_WIDTH-1:0] nor4_expect(
    input logic [4*MAX_WIDTH-1:0] stim,
    input int                     width
  );
    logic [MAX_WIDTH-1:0] lanes;
    lanes = '0;
    for (int k = 0; k < MAX_WIDTH; k++) begin
      if (k < width) begin
        lanes[k] = ~(stim[k] | stim[width+k] | stim[2*width+k] | stim[3*width+k]);
      end
    end
    return lanes;
  endfunction

endpackage

// File: rtl/nor4x2_tester_if.sv
// Board-facing bundle of the self-test driver: control, gate lanes and results.
// master = tester side, slave = board / environment side.
interface nor4x2_tester_if
  import mantle_test_pkg::*;
#(
  parameter int WIDTH = 2
);

  // START is a one-cycle request with no ready: it is acted on only while STATE
  // is IDLE or FIN and ignored otherwise. PASS/ERRCNT/FIRST_FAIL are final while DONE=1.
  logic                  START;
  logic [4*WIDTH-1:0]    STIM;
  logic [WIDTH-1:0]      RESP;
  logic                  BUSY;
  logic                  DONE;
  logic                  PASS;
  logic [ERRCNT_W-1:0]   ERRCNT;
  logic [4*WIDTH-1:0]    FIRST_FAIL;
  tester_state_t         STATE;

  modport master (
    input  START, RESP,
    output STIM, BUSY, DONE, PASS, ERRCNT, FIRST_FAIL, STATE
  );

  modport slave (
    output START, RESP,
    input  STIM, BUSY, DONE, PASS, ERRCNT, FIRST_FAIL, STATE
  );

endinterface

// File: rtl/nor4x2_tester_resp_sync.sv
// Two-flop synchronizer bringing the gate's response lanes into the CLK domain.
module resp_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_resp,
  output logic [WIDTH-1:0] o_resp_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_resp;
      r_sync <= r_meta;
    end
  end

  assign o_resp_sync = r_sync;

endmodule

// File: rtl/nor4x2_tester.sv
// Self-test driver for the NOr4x2 gate array: walks every input vector, waits for
// the response to settle, compares it with the per-lane NOR and records the results.
module nor4x2_tester
  import mantle_test_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  nor4x2_tester_if.master  bus
);

  localparam int SW = 4 * WIDTH;
  localparam int TW = $clog2(SETTLE);

  tester_state_t         r_state;
  logic [SW-1:0]         r_vec;
  logic [TW-1:0]         r_timer;
  logic [SW-1:0]         r_stim;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ERRCNT_W-1:0]   r_errcnt;
  logic [SW-1:0]         r_first_fail;
  logic                  r_fail_seen;

  logic [WIDTH-1:0]        w_resp_sync;
  logic [4*MAX_WIDTH-1:0]  w_stim_ext;
  logic [MAX_WIDTH-1:0]    w_resp_ext;
  logic [MAX_WIDTH-1:0]    w_exp;
  logic                    w_mismatch;
  logic [ERRCNT_W-1:0]     w_errcnt_next;

  resp_sync #(.WIDTH(WIDTH)) u_resp_sync (
    .clk         (CLK),
    .rst         (RESET),
    .i_resp      (bus.RESP),
    .o_resp_sync (w_resp_sync)
  );

  // Both sides are zero-extended to the widest gate so unused lanes compare equal.
  always_comb begin
    w_stim_ext             = '0;
    w_stim_ext[SW-1:0]     = r_stim;
    w_resp_ext             = '0;
    w_resp_ext[WIDTH-1:0]  = w_resp_sync;
  end

  assign w_exp         = nor4_expect(w_stim_ext, WIDTH);
  assign w_mismatch    = (w_resp_ext != w_exp);
  assign w_errcnt_next = (r_errcnt == '1) ? r_errcnt : r_errcnt + ERRCNT_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_timer      <= '0;
      r_stim       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_errcnt     <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (bus.START) begin
            r_errcnt     <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_vec        <= '0;
            r_busy       <= 1'b1;
            r_state      <= DRIVE;
          end
        end
        DRIVE: begin
          r_stim  <= r_vec;
          r_timer <= TW'(SETTLE - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_timer == '0) begin
            r_state <= CHECK;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            r_errcnt <= w_errcnt_next;
            if (!r_fail_seen) begin
              r_first_fail <= r_stim;
              r_fail_seen  <= 1'b1;
            end
          end
          // PASS must reflect this final comparison as well as the earlier ones.
          if (r_vec == '1) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_errcnt == '0);
            r_state <= FIN;
          end else begin
            r_vec   <= r_vec + SW'(1);
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.STIM       = r_stim;
  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.PASS       = r_pass;
  assign bus.ERRCNT     = r_errcnt;
  assign bus.FIRST_FAIL = r_first_fail;
  assign bus.STATE      = r_state;

endmodule

// File: tb/tb_nor4x2_tester.sv
// Bench for nor4x2_tester: a behavioural NOr4x2 gate with selectable faults drives
// RESP, and a run-timeline model predicts every output on every cycle.
module tb_nor4x2_tester;
  import mantle_test_pkg::*;

  localparam int WIDTH  = 2;
  localparam int SETTLE = 3;
  localparam int P      = SETTLE + 2;
  localparam int NV     = 256;
  localparam int FULL   = NV * P;

  logic CLK;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fault    = 0;
  int   run_c    = -1;
  int   hold_stim = 0;

  nor4x2_tester_if #(.WIDTH(WIDTH)) bus ();

  nor4x2_tester #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- gate model ----------------
  // fault: 0 good, 1 lane1 stuck-at-0, 2 lane0 stuck-at-1, 3 both lanes inverted
  function automatic logic [1:0] gate_out(input logic [7:0] v, input int f);
    logic [1:0] g;
    g[0] = ((v & 8'h55) == 8'h00);
    g[1] = ((v & 8'hAA) == 8'h00);
    case (f)
      1:       g[1] = 1'b0;
      2:       g[0] = 1'b1;
      3:       g    = ~g;
      default: ;
    endcase
    return g;
  endfunction

  always_comb bus.RESP = gate_out(bus.STIM, fault);

  // ---------------- run-timeline model ----------------
  // run_c = clock edges since the accepted START (-1 when idle after reset).
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_c     = -1;
      hold_stim = 0;
    end else if (bus.START === 1'b1 && (run_c < 0 || run_c >= FULL)) begin
      hold_stim = (run_c < 0) ? 0 : NV - 1;
      run_c     = 0;
    end else if (run_c >= 0 && run_c < FULL) begin
      run_c++;
    end
  end

  task automatic model_results(input int nchk, output int err, output int ff);
    err = 0;
    ff  = 0;
    for (int v = 0; v < nchk; v++) begin
      if (gate_out(8'(v), fault) != gate_out(8'(v), 0)) begin
        if (err == 0) ff = v;
        err++;
      end
    end
    if (err > 255) err = 255;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    int c, nchk, e_err, e_ff, e_stim;
    logic e_busy, e_done, e_pass;
    tester_state_t e_state;
    c = run_c;
    if (c < 0) begin
      e_state = IDLE; e_stim = 0; e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_ff = 0;
    end else begin
      nchk = c / P;
      if (nchk > NV) nchk = NV;
      model_results(nchk, e_err, e_ff);
      e_busy = (c < FULL);
      e_done = (c >= FULL);
      e_pass = e_done && (e_err == 0);
      if (c == 0) e_stim = hold_stim;
      else        e_stim = ((c - 1) / P > NV - 1) ? NV - 1 : (c - 1) / P;
      if (c >= FULL)          e_state = FIN;
      else if (c % P == 0)     e_state = DRIVE;
      else if (c % P == P - 1) e_state = CHECK;
      else                     e_state = WAIT;
    end
    check("cyc_state", 32'(bus.STATE), 32'(e_state));
    check("cyc_stim", 32'(bus.STIM), 32'(e_stim));
    check("cyc_busy", 32'(bus.BUSY), 32'(e_busy));
    check("cyc_done", 32'(bus.DONE), 32'(e_done));
    check("cyc_pass", 32'(bus.PASS), 32'(e_pass));
    check("cyc_errcnt", 32'(bus.ERRCNT), 32'(e_err));
    check("cyc_first_fail", 32'(bus.FIRST_FAIL), 32'(e_ff));
  end

  // ---------------- driver tasks ----------------
  task automatic do_run(input int f, input int exp_err, input int exp_ff,
                        input bit exp_pass, input bit inject, input string tag);
    int  busy_n;
    bit  done;
    busy_n = 0;
    done   = 0;
    @(negedge CLK);
    #1 fault = f;
    bus.START = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < FULL + 20 && !done; i++) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.DONE === 1'b1) begin
        done = 1;
      end else begin
        #1 bus.START = inject && (run_c == P*10 + P - 1 || run_c == P*50 + 2 || run_c == P*200);
        @(negedge CLK);
      end
    end
    bus.START = 1'b0;
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd1280);
    check({tag, "_errcnt"}, 32'(bus.ERRCNT), 32'(exp_err));
    check({tag, "_first_fail"}, 32'(bus.FIRST_FAIL), 32'(exp_ff));
    check({tag, "_pass"}, 32'(bus.PASS), 32'(exp_pass));
    check({tag, "_state"}, 32'(bus.STATE), 32'(FIN));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(bus.STATE), 32'(IDLE));
    check({tag, "_stim"}, 32'(bus.STIM), 32'd0);
    check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
    check({tag, "_done"}, 32'(bus.DONE), 32'd0);
    check({tag, "_pass"}, 32'(bus.PASS), 32'd0);
    check({tag, "_errcnt"}, 32'(bus.ERRCNT), 32'd0);
    check({tag, "_first_fail"}, 32'(bus.FIRST_FAIL), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit reached;
    bus.START = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);

    do_run(0, 0,   8'h00, 1'b1, 1'b0, "good");
    do_run(1, 16,  8'h00, 1'b0, 1'b0, "lane1_sa0");
    do_run(2, 240, 8'h01, 1'b0, 1'b0, "lane0_sa1");
    do_run(3, 255, 8'h00, 1'b0, 1'b0, "inverted");

    // Async reset in the middle of vector 100.
    @(negedge CLK);
    #1 fault = 0;
    bus.START = 1'b1;
    @(negedge CLK);
    #1 bus.START = 1'b0;
    reached = 0;
    for (int i = 0; i < FULL && !reached; i++) begin
      @(negedge CLK);
      if (run_c == P*100 + 1) reached = 1;
    end
    check("midrun_reached_vec100", 32'(bus.STIM), 32'd100);
    #2 RESET = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(negedge CLK);
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check_all_zero("after_reset");

    do_run(0, 0, 8'h00, 1'b1, 1'b0, "post_reset");
    do_run(0, 0, 8'h00, 1'b1, 1'b1, "start_while_busy");
    do_run(2, 240, 8'h01, 1'b0, 1'b0, "restart_from_fin");

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
